// File: rtl/climate_sample_scheduler.sv
// Climate sample scheduler: gathers one sample from each of three sensor
// channels (temp, humidity, pressure) with round-robin grants, hands the
// packed frame to the climate predictor, waits for its class result with a
// timeout, and holds the result until the consumer accepts it.
//
// Handshakes: a sample moves on channel i in any cycle where s_valid[i] and
// s_ready[i] are both high at the rising edge; s_ready never depends on a
// transfer in the same cycle. A result moves when res_valid and res_ready are
// both high. pred_start/pred_done are single-cycle pulses with no
// back-pressure.
module climate_sample_scheduler #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [2:0]          s_valid,
  input  logic [3*DATA_W-1:0] s_data,
  output logic [2:0]          s_ready,
  output logic                pred_start,
  output logic [3*DATA_W-1:0] pred_frame,
  input  logic                pred_done,
  input  logic [1:0]          pred_class,
  output logic                res_valid,
  output logic [1:0]          res_class,
  input  logic                res_ready,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            mask_q, mask_d;
  logic [1:0]            rr_q, rr_d;
  logic [3*DATA_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            cls_q, cls_d;
  logic                  terr_q, terr_d;
  logic [2:0]            eligible;
  logic [2:0]            grant;

  // First eligible channel found scanning upward from ptr, wrapping mod 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig,
                                         input logic [1:0] ptr);
    logic [2:0] res;
    int         c;
    res = 3'b000;
    for (int k = 0; k < 3; k++) begin
      c = (int'(ptr) + k) % 3;
      if (res == 3'b000 && elig[c]) res[c] = 1'b1;
    end
    return res;
  endfunction

  // Grant selection: only while collecting, enabled, and for uncaptured channels.
  always_comb begin
    eligible = 3'b000;
    if (state_q == COLLECT && enable) eligible = s_valid & ~mask_q;
    grant = rr_pick(eligible, rr_q);
  end

  assign s_ready     = grant;
  assign pred_frame  = frame_q;
  assign res_class   = cls_q;
  assign timeout_err = terr_q;

  // Next-state and output decode for the collect/issue/wait/output sequence.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    rr_d       = rr_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    cls_d      = cls_q;
    terr_d     = terr_q;
    pred_start = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      COLLECT: begin
        busy = 1'b0;
        if (grant != 3'b000) begin
          mask_d = mask_q | grant;
          for (int i = 0; i < 3; i++) begin
            if (grant[i]) frame_d[i*DATA_W +: DATA_W] = s_data[i*DATA_W +: DATA_W];
          end
          case (grant)
            3'b001:  rr_d = 2'd1;
            3'b010:  rr_d = 2'd2;
            default: rr_d = 2'd0;
          endcase
          if ((mask_q | grant) == 3'b111) state_d = ISSUE;
        end
      end
      ISSUE: begin
        pred_start = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // A completion in the final wait cycle still counts as success.
        if (pred_done) begin
          cls_d   = pred_class;
          state_d = OUTPUT;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          mask_d  = 3'b000;
          state_d = COLLECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          mask_d  = 3'b000;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      mask_q  <= 3'b000;
      rr_q    <= 2'd0;
      frame_q <= '0;
      cnt_q   <= '0;
      cls_q   <= 2'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rr_q    <= rr_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: doc/climate_sample_scheduler.md
CLIMATE_SAMPLE_SCHEDULER -- requirements
Module: climate_sample_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, width of one sensor sample; TIMEOUT, default 64, max WAIT cycles for pred_done.
REQ-002 Ports SHALL be (one clock; reset is synchronous and active-low):
  clk          in   1            sole clock, rising edge
  rst_n        in   1            synchronous active-low reset
  enable       in   1            permits new sample grants
  s_valid      in   3            per-channel sample valid; ch0=temp, ch1=humidity, ch2=pressure
  s_data       in   3*DATA_W     channel i at bits [i*DATA_W +: DATA_W]
  s_ready      out  3            per-channel grant; at most one bit high per cycle
  pred_start   out  1            one-cycle start pulse to climate_prediction
  pred_frame   out  3*DATA_W     packed frame; same channel layout as s_data
  pred_done    in   1            predictor completion pulse
  pred_class   in   2            predictor result, valid with pred_done
  res_valid    out  1            result available
  res_class    out  2            latched prediction class
  res_ready    in   1            result consumer accept
  busy         out  1            high in any state other than COLLECT
  timeout_err  out  1            sticky predictor-timeout flag

Function
REQ-003 FSM states SHALL be COLLECT, ISSUE, WAIT, OUTPUT; reset state COLLECT.
REQ-004 COLLECT: 3-bit capture mask tracks channels already sampled this frame.
REQ-005 s_ready SHALL be combinational: with enable=1, assert for exactly one channel that has s_valid=1 and mask bit 0, chosen round-robin; otherwise all zero.
REQ-006 Round-robin: search begins at rr_ptr, ascending mod 3; after a transfer on channel i, rr_ptr <= (i+1) mod 3.
REQ-007 Transfer (s_valid[i] & s_ready[i]) SHALL latch s_data channel i into frame register channel i and set mask bit i.
REQ-008 s_valid on an already-captured channel SHALL be ignored (no s_ready, no overwrite).
REQ-009 Cycle after the transfer that completes the mask (3'b111): state ISSUE.
REQ-010 ISSUE: pred_start=1 for exactly that cycle; next state WAIT; wait counter cleared to 0.
REQ-011 pred_frame SHALL equal the frame register at all times; frame register stays unchanged from ISSUE entry until return to COLLECT.
REQ-012 WAIT: counter increments each cycle; pred_done=1 latches pred_class into res_class, next state OUTPUT.
REQ-013 WAIT: when counter = TIMEOUT-1 and pred_done=0, set timeout_err, clear mask, go to COLLECT; no result produced.
REQ-014 pred_done=1 and counter = TIMEOUT-1 in the same cycle: pred_done wins (OUTPUT, no timeout_err).
REQ-015 pred_done outside WAIT SHALL be ignored.
REQ-016 OUTPUT: res_valid=1, res_class stable until res_ready=1; on that cycle clear mask, next state COLLECT.
REQ-017 Latency: completing transfer at cycle N -> pred_start at N+1; pred_done at M -> res_valid at M+1.
REQ-018 enable=0 SHALL block new grants only; ISSUE/WAIT/OUTPUT proceed unaffected; partial mask retained.
REQ-019 timeout_err SHALL clear only on reset.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force: state COLLECT, mask 0, rr_ptr 0, frame 0, counter 0, res_class 0, timeout_err 0; outputs s_ready 0, pred_start 0, res_valid 0, busy 0.
REQ-021 Reset mid-WAIT or mid-OUTPUT SHALL abandon the frame; a pred_done arriving after reset is ignored.

Verification
REQ-022 All three s_valid high constantly, data 0x11/0x22/0x33, enable=1 -> grants ch0,ch1,ch2 on consecutive cycles; pred_start next cycle; pred_frame=0x332211.
REQ-023 rr_ptr=1 (after a prior ch0-only grant), all valid -> grant order ch1, ch2, ch0.
REQ-024 pred_done with pred_class=2 three cycles after pred_start, res_ready low 4 cycles -> res_valid held, res_class=2 for 5 cycles, then COLLECT.
REQ-025 No pred_done, TIMEOUT=64 -> timeout_err rises 64 cycles after pred_start, stays high through next frame; pred_done at counter 63 variant -> OUTPUT, timeout_err=0.
REQ-026 enable dropped after two captures -> no s_ready for the duration; re-enable -> only remaining channel granted, frame completes.
REQ-027 rst_n low one cycle during WAIT -> all REQ-020 values next cycle; late pred_done produces no res_valid.
